// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with a valid/ready request
// and response handshake. Multiplies use one shift-add step per cycle and
// divides use one restoring-subtract step per cycle, both on operand magnitudes.
// Signs are restored in a final fix-up. Divide-by-zero and signed overflow are
// answered without iterating.
// Optional build macro MULDIV_FAST_MUL_EN selects a single-cycle combinational
// multiplier for all multiplies. Divides are unaffected by this macro.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_req_valid,
  output logic            out_req_ready,
  input  logic [XLEN-1:0] in_data1,
  input  logic [XLEN-1:0] in_data2,
  input  logic [2:0]      in_select,
  input  logic            in_kill,
  output logic            out_rsp_valid,
  input  logic            in_rsp_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_div_zero
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     b_q;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   prod_q;    // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic                neg_q;     // product / quotient sign
  logic                rneg_q;    // remainder sign (dividend sign)
  logic                rsp_valid_q;
  logic                div_zero_q;
  logic [XLEN-1:0]     data_q;

  // Negate the 2*XLEN product when needed, then pick the requested half.
  function automatic logic [XLEN-1:0] mul_result(input logic [2*XLEN-1:0] p,
                                                 input logic neg,
                                                 input logic [1:0] sel);
    logic [2*XLEN-1:0] pf;
    pf = neg ? -p : p;
    return (sel == 2'b00) ? pf[XLEN-1:0] : pf[2*XLEN-1:XLEN];
  endfunction

  // Apply quotient / remainder signs and pick the requested result.
  function automatic logic [XLEN-1:0] div_result(input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r,
                                                 input logic qneg,
                                                 input logic rneg,
                                                 input logic is_rem);
    logic [XLEN-1:0] qf;
    logic [XLEN-1:0] rf;
    qf = qneg ? -q : q;
    rf = rneg ? -r : r;
    return is_rem ? rf : qf;
  endfunction

  // Operand decode at accept time: signedness, magnitudes and special divides.
  logic            sgn1_d, sgn2_d, s1_d, s2_d;
  logic [XLEN-1:0] a_mag_d, b_mag_d;
  logic            b_zero_d, ovf_d, special_d;
  logic [XLEN-1:0] special_val_d;

  assign sgn1_d   = in_select[2] ? ~in_select[0]
                                 : (in_select[1:0] == 2'b01) || (in_select[1:0] == 2'b10);
  assign sgn2_d   = in_select[2] ? ~in_select[0] : (in_select[1:0] == 2'b01);
  assign s1_d     = sgn1_d & in_data1[XLEN-1];
  assign s2_d     = sgn2_d & in_data2[XLEN-1];
  assign a_mag_d  = s1_d ? -in_data1 : in_data1;
  assign b_mag_d  = s2_d ? -in_data2 : in_data2;
  assign b_zero_d = (in_data2 == '0);
  assign ovf_d    = ~in_select[0] && (in_data1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_data2);
  assign special_d = in_select[2] & (b_zero_d | ovf_d);
  // Divide by zero wins over overflow.
  assign special_val_d = b_zero_d ? (in_select[1] ? in_data1 : {XLEN{1'b1}})
                                  : (in_select[1] ? {XLEN{1'b0}} : in_data1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_d;
  assign fast_prod_d = (2*XLEN)'(a_mag_d) * (2*XLEN)'(b_mag_d);
`endif

  // One iteration step for each operation family.
  logic [XLEN:0]     add_sum_d;
  logic [XLEN:0]     shl_d;
  logic [XLEN:0]     diff_d;
  logic              ge_d;
  logic [2*XLEN-1:0] step_d;
  logic [XLEN-1:0]   fix_d;

  assign add_sum_d = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign shl_d     = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign diff_d    = shl_d - {1'b0, b_q};
  // The shifted remainder is below 2*divisor, so the top bit of the difference is the borrow.
  assign ge_d      = ~diff_d[XLEN];
  assign step_d    = op_q[2] ? {(ge_d ? diff_d[XLEN-1:0] : shl_d[XLEN-1:0]), prod_q[XLEN-2:0], ge_d}
                             : {add_sum_d, prod_q[XLEN-1:1]};
  assign fix_d     = op_q[2] ? div_result(step_d[XLEN-1:0], step_d[2*XLEN-1:XLEN], neg_q, rneg_q, op_q[1])
                             : mul_result(step_d, neg_q, op_q[1:0]);

  assign out_req_ready = (state_q == S_IDLE);
  assign out_rsp_valid = rsp_valid_q;
  assign out_data      = data_q;
  assign out_div_zero  = div_zero_q;

  // Control FSM with registered response outputs and iteration datapath.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
      div_zero_q  <= 1'b0;
      cnt_q       <= '0;
    end else if (in_kill) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
      div_zero_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_req_valid) begin
            op_q   <= in_select;
            b_q    <= b_mag_d;
            prod_q <= {{XLEN{1'b0}}, a_mag_d};
            neg_q  <= s1_d ^ s2_d;
            rneg_q <= s1_d;
            if (special_d) begin
              data_q      <= special_val_d;
              div_zero_q  <= b_zero_d;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!in_select[2]) begin
              data_q      <= mul_result(fast_prod_d, s1_d ^ s2_d, in_select[1:0]);
              div_zero_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
`endif
            end else begin
              div_zero_q <= 1'b0;
              cnt_q      <= CNT_W'(XLEN);
              state_q    <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          prod_q <= step_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            data_q      <= fix_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (in_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide unit, parametrised in XLEN; next-generation companion to the single-cycle funct3 ALU.
- Sits beside the ALU in the execute stage. Decode steers M-extension ops here.
- Uses a request/response valid-ready handshake so the core stalls while the unit is busy.
- Iterative datapath: one shift-add (multiply) or one restoring-subtract (divide) step per cycle.

Parameters:
- XLEN, 32: operand and result width (any even value >= 8).
- CNT_W, $clog2(XLEN)+1: iteration counter width; derived, not overridden.

Ports:
- in_clk  input  1  clock; all state changes on the rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_req_valid  input  1  request present.
- out_req_ready  output  1  unit can accept a request; high only in IDLE.
- in_data1  input  XLEN  rs1 operand.
- in_data2  input  XLEN  rs2 operand.
- in_select  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_kill  input  1  pipeline flush; aborts any operation.
- out_rsp_valid  output  1  result valid.
- in_rsp_ready  input  1  consumer takes the result.
- out_data  output  XLEN  result.
- out_div_zero  output  1  qualified by out_rsp_valid; set when a DIV/DIVU/REM/REMU had in_data2 == 0.

Behaviour:
- Reset: state IDLE; out_rsp_valid=0; out_data=0; out_div_zero=0; counter=0.
- out_req_ready = (state == IDLE). It is the only combinational output.
- States and transitions:
  - IDLE -> BUSY on accept (in_req_valid && out_req_ready). Latch operands and op. Convert signed operands to magnitudes and record the result sign. Load counter = XLEN.
  - IDLE -> DONE on accept when the op is a special divide case (see below). Result is produced with no iteration.
  - BUSY: one iteration per cycle, counter decrements. On the cycle counter reaches 1, apply sign fix-up and go to DONE.
  - DONE: out_rsp_valid=1. out_data and out_div_zero are held stable until in_rsp_ready=1, then go to IDLE. No new accept happens in that same cycle.
- Latency:
  - Accept at edge k -> out_rsp_valid high from edge k+XLEN+1 for normal ops.
  - Special cases -> out_rsp_valid high from edge k+1.
- Multiply:
  - Full 2*XLEN product.
  - MUL returns low XLEN bits. MULH, MULHSU and MULHU return high XLEN bits.
  - Signedness: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
  - Negative product is negated in 2*XLEN bits before selecting the half.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign1 XOR sign2 (signed ops only). Remainder takes the sign of the dividend.
- Special cases (RISC-V mandated, no trap):
  - Divide by zero: DIV/DIVU quotient = all ones. REM/REMU = in_data1. out_div_zero=1.
  - Signed overflow (in_data1 = most-negative, in_data2 = -1): DIV = in_data1, REM = 0.
  - Division by zero takes precedence over overflow.
- in_kill:
  - In BUSY or DONE, go to IDLE on the next edge. out_rsp_valid=0 on the next edge and no response is emitted.
  - In IDLE, it suppresses an accept in that cycle.
- in_rst has priority over in_kill; in_kill has priority over accept and response.
- Operands are changed only in registers on accept. Changes to in_data1, in_data2 or in_select while BUSY have no effect.
- in_rsp_ready outside DONE is ignored.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- When defined:
  - MUL, MULH, MULHSU and MULHU use a single-cycle combinational 2*XLEN multiplier.
  - Accept goes IDLE -> DONE; out_rsp_valid is high from edge k+1.
  - Divide ops are unchanged.
- When undefined:
  - All multiplies iterate for XLEN cycles.
  - No combinational multiplier is synthesised.

Test Plan:
1. XLEN=32, MUL 7 x 6: accept at edge k -> out_rsp_valid at edge k+33, out_data=42. With MULDIV_FAST_MUL_EN, out_rsp_valid at edge k+1.
2. MULH/MULHSU/MULHU with in_data1=0xFFFFFFFF, in_data2=2:
   - MULH -> 0xFFFFFFFF.
   - MULHSU -> 0xFFFFFFFF.
   - MULHU -> 0x00000001.
3. DIV -20/3 -> 0xFFFFFFFA (-6). REM -20/3 -> 0xFFFFFFFE (-2). DIVU 20/3 -> 6. REMU 20/3 -> 2. Each response appears XLEN+1 cycles after accept.
4. Special divides:
   - DIV 5/0 -> 0xFFFFFFFF with out_div_zero=1 at edge k+1.
   - REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM of the same operands -> 0.
5. Backpressure: hold in_rsp_ready=0 for 5 cycles after out_rsp_valid rises.
   - out_data stays stable and out_req_ready=0 throughout.
   - Raising in_rsp_ready returns the unit to IDLE next edge, and out_req_ready=1.
6. Abort: assert in_kill 10 cycles into a DIVU. Separately, assert in_rst mid-MUL.
   - Either way, next edge gives IDLE, out_rsp_valid=0, out_data=0 (after reset), with no stray response.
   - A following MUL 3 x 3 returns 9.
